// File: rtl/color_pkg.sv
// Shared types for the colour vote filter: class encoding and vote FSM states.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package color_pkg;

  localparam int COLOR_W = 2;

  typedef enum logic [COLOR_W-1:0] {
    COLOR_NONE  = 2'd0,
    COLOR_RED   = 2'd1,
    COLOR_GREEN = 2'd2,
    COLOR_BLUE  = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    STEADY    = 2'd1,
    CANDIDATE = 2'd2
  } vote_state_t;

endpackage

// File: rtl/vote_history_ring.sv
// Circular history of accepted frames (class + confidence) with fill tracking.
// Latency: write lands on the clock edge; evicted entry is combinational from wr_ptr.
// Backpressure: none; one write per cycle, the oldest entry is overwritten once full.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   clear                 synchronous clear of storage, pointer and fill
//   wr_en/wr_class/wr_conf  write one accepted frame at wr_ptr
//   evict_class/evict_conf  entry currently at wr_ptr (the one the next write replaces)
//   window_full           history holds 2**WINDOW_LOG2 frames
module vote_history_ring #(
  parameter int CLS_W       = 2,
  parameter int CONF_W      = 16,
  parameter int WINDOW_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [CLS_W-1:0]  wr_class,
  input  logic [CONF_W-1:0] wr_conf,
  output logic [CLS_W-1:0]  evict_class,
  output logic [CONF_W-1:0] evict_conf,
  output logic              window_full
);

  localparam int WINDOW = 1 << WINDOW_LOG2;

  logic [CLS_W-1:0]       cls_mem  [WINDOW];
  logic [CONF_W-1:0]      conf_mem [WINDOW];
  logic [WINDOW_LOG2-1:0] wr_ptr;
  logic [WINDOW_LOG2:0]   fill;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WINDOW; i++) begin
        cls_mem[i]  <= '0;
        conf_mem[i] <= '0;
      end
      wr_ptr <= '0;
      fill   <= '0;
    end else if (clear) begin
      for (int i = 0; i < WINDOW; i++) begin
        cls_mem[i]  <= '0;
        conf_mem[i] <= '0;
      end
      wr_ptr <= '0;
      fill   <= '0;
    end else if (wr_en) begin
      cls_mem[wr_ptr]  <= wr_class;
      conf_mem[wr_ptr] <= wr_conf;
      wr_ptr           <= wr_ptr + 1'b1;  // wraps naturally modulo WINDOW
      if (!window_full) fill <= fill + 1'b1;
    end
  end

  assign evict_class = cls_mem[wr_ptr];
  assign evict_conf  = conf_mem[wr_ptr];
  // fill saturates at WINDOW, so its MSB is set exactly when the window is full
  assign window_full = fill[WINDOW_LOG2];

endmodule

// File: rtl/color_vote_filter.sv
// N-frame majority vote filter with hysteresis for per-frame ROI colour detections.
// Latency: result_ready 2 cycles after color_valid; fully pipelined, one frame per cycle.
// Backpressure: none; every color_valid yields one result_ready unless flushed.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   flush               synchronous clear of history and state; drops any in-flight frame
//   detected_color/color_valid/color_confidence   raw per-frame detection
//   stable_color/stable_confidence   filtered class and window confidence average
//   result_ready/frame_rejected      per-frame result pulse, low-confidence flag
//   window_full, stale  history full; staleness timeout fired
// Optional feature: define COLOR_VOTE_TIMEOUT_EN to enable the staleness timeout.
module color_vote_filter
  import color_pkg::*;
#(
  parameter int NUM_CLASSES    = 4,
  parameter int WINDOW_LOG2    = 2,
  parameter int MAJORITY       = 3,
  parameter int CONF_W         = 16,
  parameter int MIN_CONFIDENCE = 100,
  parameter int HOLD_FRAMES    = 2,
  parameter int TIMEOUT_CYCLES = 2**22
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic [$clog2(NUM_CLASSES)-1:0] detected_color,
  input  logic                           color_valid,
  input  logic [CONF_W-1:0]              color_confidence,
  output logic [$clog2(NUM_CLASSES)-1:0] stable_color,
  output logic [CONF_W-1:0]              stable_confidence,
  output logic                           result_ready,
  output logic                           frame_rejected,
  output logic                           window_full,
  output logic                           stale
);

  localparam int CLS_W  = $clog2(NUM_CLASSES);
  localparam int WINDOW = 1 << WINDOW_LOG2;
  localparam int CNT_W  = WINDOW_LOG2 + 1;
  localparam int SUM_W  = CONF_W + WINDOW_LOG2;
  localparam int HW     = $clog2(HOLD_FRAMES + 1);

  if (2 * MAJORITY <= WINDOW || MAJORITY > WINDOW) begin : g_bad_majority
    $error("MAJORITY must satisfy WINDOW/2 < MAJORITY <= WINDOW");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [CLS_W-1:0]  in_class, evict_class, winner;
  logic [CONF_W-1:0] evict_conf;
  logic [SUM_W-1:0]  conf_sum, evict_term;
  logic [CNT_W-1:0]  count [NUM_CLASSES];
  logic              inc_vec [NUM_CLASSES];
  logic              dec_vec [NUM_CLASSES];
  logic              accept, below_min, s1_vld, s1_rej, eval, to_fire, found;

  vote_state_t       state, state_n;
  logic [CLS_W-1:0]  cand, cand_n, stable_n;
  logic [HW-1:0]     hold_cnt, hold_n;

  // Out-of-range classes vote as NONE.
  always_comb begin
    in_class = detected_color;
    if ({1'b0, detected_color} >= (CLS_W+1)'(NUM_CLASSES)) in_class = '0;
  end

  assign below_min = color_confidence < CONF_W'(MIN_CONFIDENCE);
  assign accept    = color_valid && !flush && !below_min;
  assign eval      = s1_vld && !s1_rej;

  vote_history_ring #(.CLS_W(CLS_W), .CONF_W(CONF_W), .WINDOW_LOG2(WINDOW_LOG2)) u_ring (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (flush || to_fire),
    .wr_en       (accept),
    .wr_class    (in_class),
    .wr_conf     (color_confidence),
    .evict_class (evict_class),
    .evict_conf  (evict_conf),
    .window_full (window_full)
  );

  // A class that is both added and evicted keeps its count.
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      inc_vec[c] = (CLS_W'(c) == in_class);
      dec_vec[c] = window_full && (CLS_W'(c) == evict_class);
    end
  end

  assign evict_term = window_full ? SUM_W'(evict_conf) : '0;

  // Lowest class index holding a strict majority; MAJORITY > WINDOW/2 rules out ties.
  always_comb begin
    winner = CLS_W'(COLOR_NONE);
    found  = 1'b0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (!found && count[c] >= CNT_W'(MAJORITY)) begin
        winner = CLS_W'(c);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    stable_n = stable_color;
    cand_n   = cand;
    hold_n   = hold_cnt;
    if (to_fire) begin
      state_n  = FILL;
      stable_n = '0;
      cand_n   = '0;
      hold_n   = '0;
    end else if (eval) begin
      case (state)
        FILL: begin
          if (window_full) begin
            state_n  = STEADY;
            stable_n = winner;
          end
        end
        STEADY: begin
          if (winner != stable_color) begin
            hold_n = HW'(1);
            if (HOLD_FRAMES == 1) begin
              stable_n = winner;
            end else begin
              state_n = CANDIDATE;
              cand_n  = winner;
            end
          end
        end
        CANDIDATE: begin
          if (winner == cand) begin
            hold_n = hold_cnt + 1'b1;
            if (hold_n >= HW'(HOLD_FRAMES)) begin
              stable_n = cand;
              state_n  = STEADY;
            end
          end else if (winner == stable_color) begin
            state_n = STEADY;
          end else begin
            cand_n = winner;
            hold_n = HW'(1);
          end
        end
        default: state_n = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CLASSES; c++) count[c] <= '0;
      conf_sum          <= '0;
      s1_vld            <= 1'b0;
      s1_rej            <= 1'b0;
      result_ready      <= 1'b0;
      frame_rejected    <= 1'b0;
      stable_confidence <= '0;
      state             <= FILL;
      stable_color      <= '0;
      cand              <= '0;
      hold_cnt          <= '0;
    end else if (flush) begin
      for (int c = 0; c < NUM_CLASSES; c++) count[c] <= '0;
      conf_sum          <= '0;
      s1_vld            <= 1'b0;
      s1_rej            <= 1'b0;
      result_ready      <= 1'b0;
      frame_rejected    <= 1'b0;
      stable_confidence <= '0;
      state             <= FILL;
      stable_color      <= '0;
      cand              <= '0;
      hold_cnt          <= '0;
    end else begin
      // stage 1: history, counters and running sum
      s1_vld <= color_valid;
      s1_rej <= below_min;
      if (to_fire) begin
        for (int c = 0; c < NUM_CLASSES; c++) count[c] <= '0;
        conf_sum <= '0;
      end else if (accept) begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
          if (inc_vec[c] && !dec_vec[c])      count[c] <= count[c] + 1'b1;
          else if (dec_vec[c] && !inc_vec[c]) count[c] <= count[c] - 1'b1;
        end
        conf_sum <= conf_sum + SUM_W'(color_confidence) - evict_term;
      end
      // stage 2: result pulse and FSM
      result_ready   <= s1_vld || to_fire;
      frame_rejected <= s1_vld && s1_rej;
      if (eval) stable_confidence <= conf_sum[SUM_W-1:WINDOW_LOG2];
      state        <= state_n;
      stable_color <= stable_n;
      cand         <= cand_n;
      hold_cnt     <= hold_n;
    end
  end

`ifdef COLOR_VOTE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            armed;

  // Only armed while the history holds something; an in-flight frame defers the timeout.
  assign to_fire = armed && (to_cnt >= TO_W'(TIMEOUT_CYCLES - 1)) && !color_valid && !s1_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
      armed  <= 1'b0;
      stale  <= 1'b0;
    end else if (flush) begin
      to_cnt <= '0;
      armed  <= 1'b0;
      stale  <= 1'b0;
    end else if (accept) begin
      to_cnt <= '0;
      armed  <= 1'b1;
      stale  <= 1'b0;
    end else if (to_fire) begin
      to_cnt <= '0;
      armed  <= 1'b0;
      stale  <= 1'b1;
    end else if (armed && to_cnt < TO_W'(TIMEOUT_CYCLES - 1)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
  assign stale   = 1'b0;
`endif

endmodule
